// File: rtl/gain_control_pkg.sv
// Shared types and elaboration-time helpers for the gain control loop:
// FSM state encoding and time-to-cycle conversions.
package gain_control_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_EVAL,
      S_SETTLE
   } state_t;

   // Rounded up so a requested delay is never shortened.
   function automatic longint us_to_cyc(input longint clk_hz, input longint t_us);
      return (clk_hz * t_us + 64'd999_999) / 64'd1_000_000;
   endfunction

   function automatic longint ms_to_cyc(input longint clk_hz, input longint t_ms);
      return (clk_hz * t_ms + 64'd999) / 64'd1_000;
   endfunction

endpackage

// File: rtl/gc_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module gc_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= value;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/gain_control.sv
// Automatic gain control: steps a combined HGA/PGA gain index from Goertzel
// power results, with a forced step-up when no result arrives in time.
module gain_control
   import gain_control_pkg::*;
#(
   parameter int          CLK_FREQ      = 50_000_000,
   parameter int          POWER_W       = 16,
   parameter int          PGA_W         = 3,
   parameter int unsigned HI_THRESH     = 16'hC000,
   parameter int unsigned LO_THRESH     = 16'h1000,
   parameter int          PGA_SETTLE_US = 50,
   parameter int          HGA_SETTLE_US = 200,
   parameter int          PRI_MS        = 1500,
   localparam int         GI_W          = PGA_W + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic [POWER_W-1:0] power_i,
   input  logic               valid_i,
   output logic               dc_block_en_o,
   output logic               goertzel_start_o,
   output logic               hga_bypass_o,
   output logic [PGA_W-1:0]   pga_gain_o,
   output logic [GI_W-1:0]    gain_idx_o,
   output logic               settling_o
);

   localparam longint PRI_CYC = ms_to_cyc(longint'(CLK_FREQ), longint'(PRI_MS));
   localparam longint PGA_CYC = us_to_cyc(longint'(CLK_FREQ), longint'(PGA_SETTLE_US));
   localparam longint HGA_CYC = us_to_cyc(longint'(CLK_FREQ), longint'(HGA_SETTLE_US));
   localparam longint MAX_A   = (PRI_CYC > PGA_CYC) ? PRI_CYC : PGA_CYC;
   localparam longint MAX_CYC = (MAX_A > HGA_CYC) ? MAX_A : HGA_CYC;
   localparam int     TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   // The timer counts down to zero inclusive, so load count-1 (zero stays one cycle).
   localparam logic [TW-1:0] PRI_LD = TW'((PRI_CYC > 0) ? PRI_CYC - 1 : 0);
   localparam logic [TW-1:0] PGA_LD = TW'((PGA_CYC > 0) ? PGA_CYC - 1 : 0);
   localparam logic [TW-1:0] HGA_LD = TW'((HGA_CYC > 0) ? HGA_CYC - 1 : 0);

   localparam logic [GI_W-1:0]    GI_RST = {1'b1, {PGA_W{1'b0}}};
   localparam logic [GI_W-1:0]    GI_MAX = '1;
   localparam logic [POWER_W-1:0] HI_TH  = POWER_W'(HI_THRESH);
   localparam logic [POWER_W-1:0] LO_TH  = POWER_W'(LO_THRESH);

   state_t              state, state_nxt;
   logic [GI_W-1:0]     gi, gi_nxt;
   logic [POWER_W-1:0]  pwr;
   logic                tmr_load, tmr_done;
   logic [TW-1:0]       tmr_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         gi    <= GI_RST;
         pwr   <= '0;
      end else begin
         state <= state_nxt;
         gi    <= gi_nxt;
         if (en_i && state == S_WAIT && valid_i)
            pwr <= power_i;
      end
   end

   always_comb begin
      state_nxt = state;
      gi_nxt    = gi;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      if (!en_i) begin
         state_nxt = S_IDLE;
         tmr_load  = 1'b1;
      end else begin
         unique case (state)
            S_IDLE:  state_nxt = S_START;
            S_START: begin
               tmr_load  = 1'b1;
               tmr_val   = PRI_LD;
               state_nxt = S_WAIT;
            end
            S_WAIT: begin
               // A result arriving on the expiry cycle takes priority.
               if (valid_i)
                  state_nxt = S_EVAL;
               else if (tmr_done) begin
                  if (gi != GI_MAX) begin
                     gi_nxt    = gi + 1'b1;
                     state_nxt = S_SETTLE;
                  end else
                     state_nxt = S_START;
               end
            end
            S_EVAL: begin
               if (pwr > HI_TH && gi != '0) begin
                  gi_nxt    = gi - 1'b1;
                  state_nxt = S_SETTLE;
               end else if (pwr < LO_TH && gi != GI_MAX) begin
                  gi_nxt    = gi + 1'b1;
                  state_nxt = S_SETTLE;
               end else
                  state_nxt = S_START;
            end
            S_SETTLE: if (tmr_done) state_nxt = S_START;
            default:  state_nxt = S_IDLE;
         endcase
         // Toggling the HGA stage needs the longer settle time.
         if (state_nxt == S_SETTLE && state != S_SETTLE) begin
            tmr_load = 1'b1;
            tmr_val  = (gi_nxt[GI_W-1] != gi[GI_W-1]) ? HGA_LD : PGA_LD;
         end
      end
   end

   gc_timer #(.W(TW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_val),
      .done  (tmr_done)
   );

   assign gain_idx_o       = gi;
   assign hga_bypass_o     = ~gi[GI_W-1];
   assign pga_gain_o       = gi[PGA_W-1:0];
   assign goertzel_start_o = (state == S_START);
   assign settling_o       = (state == S_SETTLE);
   assign dc_block_en_o    = (state == S_START) || (state == S_WAIT) || (state == S_EVAL);

endmodule

// File: tb/tb_gain_control.sv
// Scoreboard bench for gain_control: the driver queues the expected gain at
// each start pulse and each settle length; a monitor pops and compares.
module tb_gain_control;

   localparam int PGA_W = 3;
   localparam int GI_W  = PGA_W + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            en_i = 1'b0;
   logic [15:0]     power_i = '0;
   logic            valid_i = 1'b0;
   logic            dc_block_en_o, goertzel_start_o, hga_bypass_o, settling_o;
   logic [PGA_W-1:0] pga_gain_o;
   logic [GI_W-1:0] gain_idx_o;

   int tests = 0;
   int fails = 0;
   int start_q[$];
   int settle_q[$];
   int settle_cnt = 0;

   gain_control #(
      .CLK_FREQ(1_000_000), .POWER_W(16), .PGA_W(PGA_W),
      .HI_THRESH(16'hC000), .LO_THRESH(16'h1000),
      .PGA_SETTLE_US(4), .HGA_SETTLE_US(10), .PRI_MS(2)
   ) dut (
      .clk(clk), .rst(rst), .en_i(en_i), .power_i(power_i), .valid_i(valid_i),
      .dc_block_en_o(dc_block_en_o), .goertzel_start_o(goertzel_start_o),
      .hga_bypass_o(hga_bypass_o), .pga_gain_o(pga_gain_o),
      .gain_idx_o(gain_idx_o), .settling_o(settling_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compares gain outputs at every start pulse and each settle length.
   always @(negedge clk) begin
      if (goertzel_start_o) begin
         if (start_q.size() == 0) chk("unexpected_start", 1, 0);
         else begin
            int e;
            e = start_q.pop_front();
            chk("start_gain_idx", int'(gain_idx_o), e);
            chk("start_hga_bypass", int'(hga_bypass_o), (e >= 8) ? 0 : 1);
            chk("start_pga_gain", int'(pga_gain_o), e % 8);
            chk("start_dc_block", int'(dc_block_en_o), 1);
         end
      end
      if (settling_o) settle_cnt++;
      else if (settle_cnt > 0) begin
         if (settle_q.size() == 0) chk("unexpected_settle", settle_cnt, 0);
         else chk("settle_len", settle_cnt, settle_q.pop_front());
         settle_cnt = 0;
      end
   end

   // Advances to the next start pulse; returns negedges elapsed.
   task automatic wait_start(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!goertzel_start_o && n < 5000);
      chk("start_seen", int'(goertzel_start_o), 1);
   endtask

   // All stimulus tasks begin and end on a start-pulse negedge.
   task automatic send(input logic [15:0] p, input int exp_gi, input int exp_settle);
      int n;
      @(negedge clk);
      valid_i = 1'b1;
      power_i = p;
      @(negedge clk);
      valid_i = 1'b0;
      if (exp_settle > 0) settle_q.push_back(exp_settle);
      start_q.push_back(exp_gi);
      wait_start(n);
   endtask

   task automatic timeout(input int exp_gi, input int exp_settle, output int n);
      if (exp_settle > 0) settle_q.push_back(exp_settle);
      start_q.push_back(exp_gi);
      wait_start(n);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_gain_idx", int'(gain_idx_o), 8);
      chk("rst_hga_bypass", int'(hga_bypass_o), 0);
      chk("rst_pga_gain", int'(pga_gain_o), 0);
      chk("rst_dc_block", int'(dc_block_en_o), 0);
      chk("rst_start", int'(goertzel_start_o), 0);
      chk("rst_settling", int'(settling_o), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_dc_block", int'(dc_block_en_o), 0);

      start_q.push_back(8);
      en_i = 1'b1;
      wait_start(n);
      chk("first_start_latency", n, 1);

      send(16'hF000, 7, 10);
      for (int g = 7; g > 3; g--) send(16'hF000, g - 1, 4);
      send(16'h0800, 4, 4);
      send(16'h1000, 4, 0);
      send(16'hC000, 4, 0);

      // Result on the PRI expiry cycle: in-band, so no forced step.
      repeat (2000) @(negedge clk);
      valid_i = 1'b1;
      power_i = 16'h8000;
      @(negedge clk);
      valid_i = 1'b0;
      start_q.push_back(4);
      wait_start(n);

      timeout(5, 4, n);
      for (int g = 5; g < 15; g++) send(16'h0800, g + 1, (g == 7) ? 10 : 4);
      send(16'h0000, 15, 0);
      timeout(15, 0, n);
      chk("pri_sat_spacing", n, 2001);

      for (int g = 15; g > 0; g--) send(16'hFFFF, g - 1, (g == 8) ? 10 : 4);
      send(16'hFFFF, 0, 0);

      // Drop enable during settle.
      @(negedge clk);
      valid_i = 1'b1;
      power_i = 16'h0800;
      @(negedge clk);
      valid_i = 1'b0;
      settle_q.push_back(1);
      n = 0;
      while (!settling_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("settle_seen", int'(settling_o), 1);
      en_i = 1'b0;
      @(negedge clk);
      chk("drop_settling", int'(settling_o), 0);
      chk("drop_dc_block", int'(dc_block_en_o), 0);
      chk("drop_start", int'(goertzel_start_o), 0);
      chk("drop_gain_idx", int'(gain_idx_o), 1);
      repeat (3) @(negedge clk);
      chk("idle_hold_gain", int'(gain_idx_o), 1);
      start_q.push_back(1);
      en_i = 1'b1;
      wait_start(n);
      repeat (3) @(negedge clk);
      chk("start_q_drained", start_q.size(), 0);
      chk("settle_q_drained", settle_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
